// File: rtl/softmax_pkg.sv
// Shared types and helpers for the softmax normalisation stage.
package softmax_pkg;

   typedef enum logic [1:0] {
      ACC  = 2'd0,
      DIV  = 2'd1,
      EMIT = 2'd2
   } norm_state_t;

   // ln(2) in Q.8, kept alongside the exp-stage constants
   localparam int unsigned LN2_Q8 = 177;

   // Clamp an unsigned value to the largest value representable in ow bits
   function automatic logic [127:0] sat_u(input logic [127:0] val, input int unsigned ow);
      logic [127:0] max_v;
      max_v = (128'd1 << ow) - 128'd1;
      return (val > max_v) ? max_v : val;
   endfunction

endpackage

// File: rtl/softmax_norm_recip_div.sv
// Sequential restoring divider: quotient = floor(2^K / divisor).
// One quotient bit per cycle, K+1 cycles after start; done marks the final iteration.
module recip_div #(
   parameter int unsigned SW = 34,
   parameter int unsigned K  = 42
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [SW-1:0] divisor,
   output logic          busy,
   output logic          done,
   output logic [K:0]    quotient
);

   localparam int unsigned CW = $clog2(K + 2);

   logic [CW-1:0] r_cnt;
   logic [SW-1:0] r_rem;
   logic [SW-1:0] r_div;
   logic [K:0]    r_q;

   logic [SW:0]   w_shift;
   logic          w_ge;
   logic [SW:0]   w_diff;

   // Dividend is 2^K: only its first (most significant) bit is one
   assign w_shift = {r_rem, (r_cnt == CW'(K + 1))};
   assign w_ge    = (w_shift >= {1'b0, r_div});
   assign w_diff  = w_shift - {1'b0, r_div};

   assign busy     = (r_cnt != '0);
   assign done     = (r_cnt == CW'(1));
   assign quotient = r_q;

   // Load on start, then one restoring step per cycle until the count runs out
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_rem <= '0;
         r_div <= '0;
         r_q   <= '0;
      end else if (start) begin
         r_cnt <= CW'(K + 1);
         r_rem <= '0;
         r_div <= divisor;
         r_q   <= '0;
      end else if (r_cnt != '0) begin
         r_rem <= w_ge ? w_diff[SW-1:0] : w_shift[SW-1:0];
         r_q   <= {r_q[K-1:0], w_ge};
         r_cnt <= r_cnt - CW'(1);
      end
   end

endmodule

// File: rtl/softmax_norm.sv
// softmax_norm: buffers one vector of Q.8 exp values, computes 1/sum once with a
// restoring divider, then streams x_i/sum in unsigned Q.FRAC.
// Build option: SOFTMAX_NORM_ROUND_EN selects round-half-up instead of truncation.
module softmax_norm
   import softmax_pkg::*;
#(
   parameter int unsigned DW   = 32,
   parameter int unsigned N    = 8,
   parameter int unsigned FRAC = 8,
   parameter int unsigned OW   = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   input  logic          in_last,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [OW-1:0] out_data,
   output logic          out_last,
   output logic          busy,
   output logic          err
);

   localparam int unsigned IW = $clog2(N);
   localparam int unsigned CW = IW + 1;
   localparam int unsigned SW = DW + IW;
   localparam int unsigned K  = SW + FRAC;
   localparam int unsigned PW = DW + K + 1;

   norm_state_t   r_state, w_state_nxt;
   logic [DW-1:0] r_buf [N];
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] r_idx;
   logic [SW-1:0] r_sum;
   logic          r_err;

   logic [DW-1:0] w_x;
   logic [SW-1:0] w_sum_nxt;
   logic          w_in_fire;
   logic          w_out_fire;
   logic          w_vec_end;
   logic          w_start;
   logic          w_div_done;
   logic          w_div_busy;
   logic [K:0]    w_quot;
   logic [K:0]    w_recip;
   logic [PW-1:0] w_prod;
   logic [PW-1:0] w_scaled;
   logic [127:0]  w_sat;
   logic          w_last_el;
   logic          w_unused;

   assign w_x        = in_data[DW-1] ? '0 : in_data;
   assign w_sum_nxt  = r_sum + SW'(w_x);
   assign w_in_fire  = in_valid && in_ready;
   assign w_out_fire = out_valid && out_ready;
   assign w_vec_end  = in_last || (r_cnt == CW'(N - 1));
   // Zero sum never starts the divider; DIV handles it in a single cycle
   assign w_start    = w_in_fire && w_vec_end && (w_sum_nxt != '0);

   recip_div #(
      .SW (SW),
      .K  (K)
   ) u_recip_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (w_start),
      .divisor  (w_sum_nxt),
      .busy     (w_div_busy),
      .done     (w_div_done),
      .quotient (w_quot)
   );

   assign w_recip   = (r_sum == '0) ? '0 : w_quot;
   assign w_prod    = PW'(r_buf[r_idx[IW-1:0]]) * PW'(w_recip);
`ifdef SOFTMAX_NORM_ROUND_EN
   assign w_scaled  = (w_prod + (PW'(1) << (SW - 1))) >> SW;
`else
   assign w_scaled  = w_prod >> SW;
`endif
   assign w_sat     = sat_u(128'(w_scaled), OW);
   assign w_last_el = (r_idx == r_cnt - CW'(1));
   assign w_unused  = ^{w_sat[127:OW], w_div_busy};

   // Next-state and handshake outputs
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b0;
      unique case (r_state)
         ACC: begin
            in_ready = 1'b1;
            if (w_in_fire && w_vec_end) w_state_nxt = DIV;
         end
         DIV: begin
            busy = 1'b1;
            if (r_sum == '0 || w_div_done) w_state_nxt = EMIT;
         end
         EMIT: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (w_out_fire && w_last_el) w_state_nxt = ACC;
         end
         default: w_state_nxt = ACC;
      endcase
   end

   assign out_data = out_valid ? w_sat[OW-1:0] : '0;
   assign out_last = out_valid && w_last_el;
   assign err      = r_err;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ACC;
      else        r_state <= w_state_nxt;
   end

   // Buffer fill, running sum, emit index and sticky error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(N); i++) r_buf[i] <= '0;
         r_cnt <= '0;
         r_idx <= '0;
         r_sum <= '0;
         r_err <= 1'b0;
      end else begin
         unique case (r_state)
            ACC: begin
               if (w_in_fire) begin
                  r_buf[r_cnt[IW-1:0]] <= w_x;
                  r_sum                <= w_sum_nxt;
                  r_cnt                <= r_cnt + CW'(1);
                  if (r_cnt == CW'(N - 1) && !in_last) r_err <= 1'b1;
               end
            end
            DIV: begin
               if (r_sum == '0) r_err <= 1'b1;
            end
            EMIT: begin
               if (w_out_fire) begin
                  if (w_last_el) begin
                     r_cnt <= '0;
                     r_sum <= '0;
                     r_idx <= '0;
                  end else begin
                     r_idx <= r_idx + CW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_softmax_norm.sv
// Randomised and directed bench for softmax_norm (DW=32, N=4, FRAC=8, OW=16).
module tb_softmax_norm;

   localparam int unsigned DW   = 32;
   localparam int unsigned N    = 4;
   localparam int unsigned FRAC = 8;
   localparam int unsigned OW   = 16;
   localparam int unsigned SW   = 34;
   localparam int unsigned K    = 42;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [OW-1:0] out_data;
   logic          out_last;
   logic          busy;
   logic          err;

   int  n_vec  = 0;
   int  n_fail = 0;
   bit  m_err  = 1'b0;

   always #5 clk = ~clk;

   softmax_norm #(
      .DW   (DW),
      .N    (N),
      .FRAC (FRAC),
      .OW   (OW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy),
      .err       (err)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: probability = x * floor(2^K/sum) / 2^SW, saturated to OW bits
   function automatic int unsigned ref_prob(input longint unsigned x, input longint unsigned sum);
      logic [127:0] r;
      logic [127:0] p;
      if (sum == 0) return 0;
      r = (128'd1 << K) / 128'(sum);
      p = 128'(x) * r;
`ifdef SOFTMAX_NORM_ROUND_EN
      p = p + (128'd1 << (SW - 1));
`endif
      p = p >> SW;
      if (p > 128'd65535) p = 128'd65535;
      return int'(p[31:0]);
   endfunction

   task automatic run_vec(input int vals[$], input bit use_last, input int stall_idx,
                          input int exp_d[$], input int exp_lat, input bit exp_err);
      int n;
      int lat;
      n = vals.size();
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_data  = vals[i];
         in_last  = use_last && (i == n - 1);
         chk("in_ready", in_ready, 1);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("busy_div", busy, 1);
      lat = 0;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("div_latency", lat, exp_lat);
      if (!out_valid) return;
      for (int i = 0; i < n; i++) begin
         if (i == stall_idx) begin
            out_ready = 1'b0;
            repeat (10) begin
               @(posedge clk); #1;
               chk("stall_hold", out_data, exp_d[i]);
            end
         end else if ($urandom_range(0, 3) == 0) begin
            out_ready = 1'b0;
            @(posedge clk); #1;
         end
         out_ready = 1'b1;
         chk("out_valid", out_valid, 1);
         chk("out_data", out_data, exp_d[i]);
         chk("out_last", out_last, (i == n - 1));
         @(posedge clk); #1;
      end
      out_ready = 1'b0;
      chk("back_in_ready", in_ready, 1);
      chk("out_valid_low", out_valid, 0);
      chk("err", err, exp_err);
   endtask

   // Model-driven vector: computes expectations and the sticky error from the rules
   task automatic run_model(input int vals[$], input bit use_last, input int stall_idx);
      longint unsigned sum;
      longint unsigned xs[$];
      int exp_d[$];
      sum = 0;
      foreach (vals[i]) begin
         xs.push_back((vals[i] < 0) ? 0 : longint'(vals[i]));
         sum += xs[i];
      end
      foreach (xs[i]) exp_d.push_back(ref_prob(xs[i], sum));
      if (sum == 0 || !use_last) m_err = 1'b1;
      run_vec(vals, use_last, stall_idx, exp_d, (sum == 0) ? 1 : int'(K) + 1, m_err);
   endtask

   task automatic rand_vec(input int stall_idx);
      int v[$];
      int len;
      bit ul;
      len = $urandom_range(1, N);
      ul  = (len != N) || ($urandom_range(0, 5) != 0);
      for (int i = 0; i < len; i++) begin
         case ($urandom_range(0, 5))
            0:       v.push_back(-int'($urandom_range(1, 1000)));
            1:       v.push_back(int'($urandom & 32'h7fff_ffff));
            default: v.push_back(int'($urandom_range(0, 1 << 20)));
         endcase
      end
      run_model(v, ul, stall_idx);
   endtask

   initial begin
      int v[$];
      int e[$];
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      v = '{256, 256, 256, 256}; e = '{64, 64, 64, 64};
      run_vec(v, 1'b1, -1, e, 43, 1'b0);
      v = '{256, 0, 0, 0};       e = '{256, 0, 0, 0};
      run_vec(v, 1'b1, -1, e, 43, 1'b0);
      v = '{100, 50, 50, 56};    e = '{100, 50, 50, 56};
      run_vec(v, 1'b1, -1, e, 43, 1'b0);
      v = '{256, 256, 256};      e = '{85, 85, 85};
      run_vec(v, 1'b1, -1, e, 43, 1'b0);
      // Backpressure mid-EMIT
      v = '{1000, 2000, 3000, 4000};
      run_model(v, 1'b1, 2);

      for (int t = 0; t < 12; t++) rand_vec(($urandom_range(0, 3) == 0) ? 1 : -1);

      v = '{-5, 0, 0, 0};        e = '{0, 0, 0, 0};
      run_vec(v, 1'b1, -1, e, 1, 1'b1);
      m_err = 1'b1;
      v = '{256, 256, 256, 256}; e = '{64, 64, 64, 64};
      run_vec(v, 1'b0, -1, e, 43, 1'b1);

      // Reset in the middle of DIV
      v = '{256, 256, 256, 256};
      foreach (v[i]) begin
         in_valid = 1'b1;
         in_data  = v[i];
         in_last  = (i == 3);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("pre_rst_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_err", err, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_err = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_in_ready", in_ready, 1);
      e = '{64, 64, 64, 64};
      run_vec(v, 1'b1, -1, e, 43, 1'b0);

      for (int t = 0; t < 8; t++) rand_vec(-1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation time limit");
   end

endmodule
